capture_ctrl: RTL
=================

CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 Parameter ENTRIES, default 384, sample RAM depth (12288 on DE-0).
REQ-002 Parameter LOG2, default 9, address width, ceil(log2(ENTRIES)).
REQ-003 clk  input  1  system clock; one clock domain, all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 wrt_smpl  input  1  one-cycle strobe from the decimated sample clock; a sample is ready to write.
REQ-006 run  input  1  run bit (TrigCfg[4]); 1 enables capture.
REQ-007 capture_done  input  1  capture-done status bit (TrigCfg[5]); host clears it after dump.
REQ-008 triggered  input  1  trigger logic has fired; level or pulse.
REQ-009 trig_pos  input  LOG2  number of samples to capture after the trigger.
REQ-010 we  output  1  write enable to all five RAM queues.
REQ-011 waddr  output  LOG2  write address to RAM queues; equals oldest entry when capture completes.
REQ-012 set_capture_done  output  1  one-cycle pulse that sets TrigCfg[5].
REQ-013 armed  output  1  enough pre-trigger samples are stored; trigger logic may fire.

Function
REQ-014 FSM states SHALL be IDLE, CAPTURE and WAIT_RD.
REQ-015 IDLE: we=0, armed=0; run=1 with capture_done=0 -> CAPTURE next cycle, smpl_cnt, trig_cnt and trig_latched cleared, waddr held.
REQ-016 CAPTURE: we SHALL equal wrt_smpl combinationally, same cycle; waddr increments on the following edge.
REQ-017 waddr SHALL wrap from ENTRIES-1 to 0, never reaching ENTRIES.
REQ-018 smpl_cnt (LOG2+1 bits) SHALL increment on each write and saturate at ENTRIES.
REQ-019 armed SHALL be 1 in CAPTURE when smpl_cnt >= ENTRIES - trig_pos; if trig_pos >= ENTRIES, armed is 1 from entry to CAPTURE.
REQ-020 triggered=1 while armed=1 SHALL set trig_latched; triggered with armed=0 is ignored.
REQ-021 trig_cnt SHALL increment only on writes in cycles where trig_latched is already 1; a write coinciding with the trigger cycle is pre-trigger.
REQ-022 When trig_latched=1 and trig_cnt == trig_pos: set_capture_done pulses for one cycle, we forced 0, and the FSM goes to WAIT_RD.
REQ-023 trig_pos=0: completion SHALL occur the cycle after trig_latched sets, with no post-trigger writes.
REQ-024 run=0 in CAPTURE SHALL abort to IDLE next cycle: we=0 in that cycle, no set_capture_done, waddr retained.
REQ-025 WAIT_RD: we=0, armed=0; the FSM holds until capture_done=0, then goes to IDLE, ignoring run and wrt_smpl.
REQ-026 capture_done=1 seen in IDLE SHALL block the start of a new capture.
REQ-027 set_capture_done SHALL never assert outside the CAPTURE->WAIT_RD transition.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, waddr=0, smpl_cnt=0, trig_cnt=0, trig_latched=0, we=0, armed=0, set_capture_done=0.
REQ-029 Reset mid-capture SHALL discard progress with no set_capture_done pulse; capture resumes only via REQ-015.

Structure
REQ-030 The capture state enum (IDLE, CAPTURE, WAIT_RD) SHALL live in shared package la_pkg; ENTRIES and LOG2 remain module parameters.
REQ-031 The wrapping address counter SHALL be sub-module addr_wrap_cnt (ld, inc, wrap at ENTRIES-1), reusable by the dump read path.
REQ-032 All outputs except we and armed SHALL be registered; we and armed are combinational from state and registered counters only.

Verification
REQ-033 Reset release -> all outputs 0, waddr=0, FSM in IDLE for 10 cycles with run=0.
REQ-034 run=1, trig_pos=10, wrt_smpl every 4 clk -> armed rises after write 374; trigger pulse -> exactly 10 further we pulses, then one set_capture_done pulse.
REQ-035 Keep armed without trigger for 400 writes -> waddr goes 383 -> 0, smpl_cnt saturates at 384, we continues.
REQ-036 Drop run after 50 writes -> we stops the same cycle, FSM returns to IDLE, no set_capture_done, waddr=50.
REQ-037 Hold capture_done=1 after completion for 100 cycles with run=1 -> no we pulses; release -> IDLE, then new CAPTURE from the retained waddr.
REQ-038 trig_pos=0, triggered while armed -> set_capture_done one cycle later, zero post-trigger writes; also assert rst_n mid-capture -> immediate IDLE with waddr=0.

Source files
------------

// File: rtl/la_pkg.sv
// Shared logic-analyzer definitions: capture FSM state encoding used by the
// capture controller and anything that observes its state.
package la_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    WAIT_RD = 2'd2
  } cap_state_e;

endpackage

// File: rtl/addr_wrap_cnt.sv
// Modulo-ENTRIES address counter with synchronous load; shared by the capture
// write path and the dump read path.
module addr_wrap_cnt #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ld_i,
  input  logic [LOG2-1:0] ld_val_i,
  input  logic            inc_i,
  output logic [LOG2-1:0] cnt_o
);

  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

  logic [LOG2-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (ld_i) begin
      cnt_q <= ld_val_i;
    end else if (inc_i) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/capture_ctrl.sv
// Capture controller: fills the circular sample RAM, arms the trigger once
// enough pre-trigger history is stored, and stops trig_pos samples after it.
module capture_ctrl
  import la_pkg::*;
#(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wrt_smpl,
  input  logic            run,
  input  logic            capture_done,
  input  logic            triggered,
  input  logic [LOG2-1:0] trig_pos,
  output logic            we,
  output logic [LOG2-1:0] waddr,
  output logic            set_capture_done,
  output logic            armed,
  output cap_state_e      dbg_state
);

  // wrt_smpl is a single-cycle strobe with no back-pressure: a sample offered
  // while we=0 is dropped, a sample with we=1 is written this same cycle.
  localparam logic [LOG2:0] FULL = (LOG2+1)'(ENTRIES);

  cap_state_e      state_q;
  logic [LOG2:0]   smpl_cnt_q;
  logic [LOG2:0]   smpl_cnt_d;
  logic [LOG2-1:0] trig_cnt_q;
  logic            trig_latched_q;
  logic            set_done_q;

  logic [LOG2:0]   trig_pos_x;
  logic [LOG2:0]   arm_thresh;
  logic            pos_ge_full;
  logic            done_hit;

  assign trig_pos_x  = {1'b0, trig_pos};
  assign pos_ge_full = (trig_pos_x >= FULL);
  assign arm_thresh  = FULL - trig_pos_x;
  assign smpl_cnt_d  = (smpl_cnt_q == FULL) ? FULL : smpl_cnt_q + 1'b1;
  assign done_hit    = trig_latched_q && (trig_cnt_q == trig_pos);

  assign armed = (state_q == CAPTURE) && (pos_ge_full || (smpl_cnt_q >= arm_thresh));
  assign we    = (state_q == CAPTURE) && run && wrt_smpl && !done_hit;

  addr_wrap_cnt #(
    .ENTRIES (ENTRIES),
    .LOG2    (LOG2)
  ) u_waddr (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_i     (1'b0),
    .ld_val_i ('0),
    .inc_i    (we),
    .cnt_o    (waddr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      smpl_cnt_q     <= '0;
      trig_cnt_q     <= '0;
      trig_latched_q <= 1'b0;
      set_done_q     <= 1'b0;
    end else begin
      set_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (run && !capture_done) begin
            state_q        <= CAPTURE;
            smpl_cnt_q     <= '0;
            trig_cnt_q     <= '0;
            trig_latched_q <= 1'b0;
          end
        end
        CAPTURE: begin
          if (!run) begin
            state_q <= IDLE;
          end else if (done_hit) begin
            state_q    <= WAIT_RD;
            set_done_q <= 1'b1;
          end else begin
            if (we) begin
              smpl_cnt_q <= smpl_cnt_d;
              if (trig_latched_q) trig_cnt_q <= trig_cnt_q + 1'b1;
            end
            if (triggered && armed) trig_latched_q <= 1'b1;
          end
        end
        WAIT_RD: begin
          // The host bit is set one cycle after our pulse, so a still-clear
          // capture_done during the pulse cycle must not release us.
          if (!set_done_q && !capture_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign set_capture_done = set_done_q;
  assign dbg_state        = state_q;

endmodule
